// File: rtl/axi4_lite_slave_bridge.sv
// AXI4-Lite slave that decodes one address window and forwards single accesses
// to a simple req/ack peripheral port, with DECERR for misses and SLVERR on timeout.
module axi4_lite_slave_bridge #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter int unsigned            SIZE_BYTES = 4096,
    parameter int unsigned            TIMEOUT    = 15
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,

    output logic                      per_req,
    output logic                      per_we,
    output logic [ADDR_WIDTH-1:0]     per_addr,
    output logic [DATA_WIDTH-1:0]     per_wdata,
    output logic [DATA_WIDTH/8-1:0]   per_be,
    input  logic [DATA_WIDTH-1:0]     per_rdata,
    input  logic                      per_ack
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = 8;
    localparam logic [ADDR_WIDTH:0]    SIZE_EXT   = (ADDR_WIDTH+1)'(SIZE_BYTES);
    localparam logic [CNT_WIDTH-1:0]   TIMEOUT_M1 = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0]   w_strb_q, w_strb_d;
    logic                    awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d, resp_code_q, resp_code_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    per_req_q, per_req_d, per_we_q, per_we_d;
    logic [ADDR_WIDTH-1:0]   per_addr_q, per_addr_d;
    logic [DATA_WIDTH-1:0]   per_wdata_q, per_wdata_d;
    logic [STRB_WIDTH-1:0]   per_be_q, per_be_d;
    logic                    cur_write_q, cur_write_d, prefer_write_q, prefer_write_d;
    logic [CNT_WIDTH-1:0]    wait_cnt_q, wait_cnt_d;

    logic                    write_rdy, read_rdy, grant_write, in_range;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic [ADDR_WIDTH:0]     offset_ext;

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            aw_held_q      <= 1'b0;
            w_held_q       <= 1'b0;
            ar_held_q      <= 1'b0;
            aw_addr_q      <= '0;
            ar_addr_q      <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            awready_q      <= 1'b0;
            wready_q       <= 1'b0;
            arready_q      <= 1'b0;
            bvalid_q       <= 1'b0;
            rvalid_q       <= 1'b0;
            bresp_q        <= '0;
            rresp_q        <= '0;
            resp_code_q    <= '0;
            rdata_q        <= '0;
            per_req_q      <= 1'b0;
            per_we_q       <= 1'b0;
            per_addr_q     <= '0;
            per_wdata_q    <= '0;
            per_be_q       <= '0;
            cur_write_q    <= 1'b0;
            prefer_write_q <= 1'b0;
            wait_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            aw_held_q      <= aw_held_d;
            w_held_q       <= w_held_d;
            ar_held_q      <= ar_held_d;
            aw_addr_q      <= aw_addr_d;
            ar_addr_q      <= ar_addr_d;
            w_data_q       <= w_data_d;
            w_strb_q       <= w_strb_d;
            awready_q      <= awready_d;
            wready_q       <= wready_d;
            arready_q      <= arready_d;
            bvalid_q       <= bvalid_d;
            rvalid_q       <= rvalid_d;
            bresp_q        <= bresp_d;
            rresp_q        <= rresp_d;
            resp_code_q    <= resp_code_d;
            rdata_q        <= rdata_d;
            per_req_q      <= per_req_d;
            per_we_q       <= per_we_d;
            per_addr_q     <= per_addr_d;
            per_wdata_q    <= per_wdata_d;
            per_be_q       <= per_be_d;
            cur_write_q    <= cur_write_d;
            prefer_write_q <= prefer_write_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    // Channel capture, arbitration and access sequencing
    always_comb begin
        state_d        = state_q;
        aw_held_d      = aw_held_q;
        w_held_d       = w_held_q;
        ar_held_d      = ar_held_q;
        aw_addr_d      = aw_addr_q;
        ar_addr_d      = ar_addr_q;
        w_data_d       = w_data_q;
        w_strb_d       = w_strb_q;
        bvalid_d       = bvalid_q;
        rvalid_d       = rvalid_q;
        bresp_d        = bresp_q;
        rresp_d        = rresp_q;
        resp_code_d    = resp_code_q;
        rdata_d        = rdata_q;
        per_req_d      = per_req_q;
        per_we_d       = per_we_q;
        per_addr_d     = per_addr_q;
        per_wdata_d    = per_wdata_q;
        per_be_d       = per_be_q;
        cur_write_d    = cur_write_q;
        prefer_write_d = prefer_write_q;
        wait_cnt_d     = wait_cnt_q;

        write_rdy   = aw_held_q && w_held_q;
        read_rdy    = ar_held_q;
        grant_write = write_rdy && (!read_rdy || prefer_write_q);
        grant_addr  = grant_write ? aw_addr_q : ar_addr_q;
        // Borrow bit of the widened subtraction flags addresses below the window
        offset_ext  = {1'b0, grant_addr} - {1'b0, BASE_ADDR};
        in_range    = !offset_ext[ADDR_WIDTH] && ({1'b0, offset_ext[ADDR_WIDTH-1:0]} < SIZE_EXT);

        if (S_AXI_AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (S_AXI_ARVALID && arready_q) begin
            ar_held_d = 1'b1;
            ar_addr_d = S_AXI_ARADDR;
        end

        case (state_q)
            IDLE: begin
                if (write_rdy || read_rdy) begin
                    // Priority only flips on a contested grant
                    if (write_rdy && read_rdy) begin
                        prefer_write_d = !grant_write;
                    end
                    cur_write_d = grant_write;
                    if (in_range) begin
                        state_d     = ACCESS;
                        per_req_d   = 1'b1;
                        per_we_d    = grant_write;
                        per_addr_d  = offset_ext[ADDR_WIDTH-1:0];
                        per_wdata_d = grant_write ? w_data_q : '0;
                        per_be_d    = grant_write ? w_strb_q : '0;
                        wait_cnt_d  = '0;
                    end else begin
                        state_d     = RESP;
                        resp_code_d = RESP_DECERR;
                    end
                end
            end
            ACCESS: begin
                if (per_ack || (wait_cnt_q == TIMEOUT_M1)) begin
                    state_d   = RESP;
                    per_req_d = 1'b0;
                    if (cur_write_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = per_ack ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = per_ack ? RESP_OKAY : RESP_SLVERR;
                        rdata_d  = per_ack ? per_rdata : '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
                end
            end
            RESP: begin
                if (!bvalid_q && !rvalid_q) begin
                    bvalid_d = cur_write_q;
                    rvalid_d = !cur_write_q;
                    if (cur_write_q) begin
                        bresp_d = resp_code_q;
                    end else begin
                        rresp_d = resp_code_q;
                    end
                end else if (bvalid_q && S_AXI_BREADY) begin
                    state_d   = IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = '0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end else if (rvalid_q && S_AXI_RREADY) begin
                    state_d   = IDLE;
                    rvalid_d  = 1'b0;
                    rresp_d   = '0;
                    rdata_d   = '0;
                    ar_held_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
        arready_d = !ar_held_d && !rvalid_d;
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign per_req       = per_req_q;
    assign per_we        = per_we_q;
    assign per_addr      = per_addr_q;
    assign per_wdata     = per_wdata_q;
    assign per_be        = per_be_q;

endmodule

// File: tb/tb_axi4_lite_slave_bridge.sv
// Directed bench for axi4_lite_slave_bridge: decode, wait/ack timing, DECERR,
// timeout, arbitration order, B backpressure and mid-access reset.
module tb_axi4_lite_slave_bridge;

    localparam int unsigned   AW   = 32;
    localparam int unsigned   DW   = 32;
    localparam int unsigned   SW   = DW / 8;
    localparam logic [AW-1:0] BASE = 32'h4000_0000;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [AW-1:0]  awaddr = '0, araddr = '0;
    logic           awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic           bready = 1'b0, rready = 1'b0;
    logic [DW-1:0]  wdata = '0;
    logic [SW-1:0]  wstrb = '0;
    logic           awready, wready, arready, bvalid, rvalid;
    logic [1:0]     bresp, rresp;
    logic [DW-1:0]  rdata;
    logic           per_req, per_we, per_ack = 1'b0;
    logic [AW-1:0]  per_addr;
    logic [DW-1:0]  per_wdata, per_rdata = '0;
    logic [SW-1:0]  per_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi4_lite_slave_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (BASE),
        .SIZE_BYTES (4096),
        .TIMEOUT    (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .per_req       (per_req),
        .per_we        (per_we),
        .per_addr      (per_addr),
        .per_wdata     (per_wdata),
        .per_be        (per_be),
        .per_rdata     (per_rdata),
        .per_ack       (per_ack)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset state
        step();
        step();
        chk("rst_awready", 64'(awready), 64'h0);
        chk("rst_wready",  64'(wready),  64'h0);
        chk("rst_arready", 64'(arready), 64'h0);
        chk("rst_bvalid",  64'(bvalid),  64'h0);
        chk("rst_rvalid",  64'(rvalid),  64'h0);
        chk("rst_per_req", 64'(per_req), 64'h0);
        chk("rst_rdata",   64'(rdata),   64'h0);
        chk("rst_per_sig", 64'({per_we, per_be, per_addr}), 64'h0);
        rst = 1'b1;
        #1;
        chk("ready_before_edge", 64'(awready), 64'h0);
        step();
        chk("ready_first_edge", 64'({awready, wready, arready}), 64'h7);

        // Write: AW first, W three cycles later, immediate ack
        awaddr = BASE + 32'h10; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("aw_captured_ready_low", 64'(awready), 64'h0);
        step();
        step();
        chk("w_only_no_req", 64'(per_req), 64'h0);
        wdata = 32'hDEADBEEF; wstrb = 4'b0011; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        per_ack = 1'b1;
        step();
        chk("wr_per_req",   64'(per_req),   64'h1);
        chk("wr_per_we",    64'(per_we),    64'h1);
        chk("wr_per_addr",  64'(per_addr),  64'h10);
        chk("wr_per_be",    64'(per_be),    64'h3);
        chk("wr_per_wdata", 64'(per_wdata), 64'hDEADBEEF);
        step();
        per_ack = 1'b0;
        chk("wr_bvalid", 64'(bvalid),  64'h1);
        chk("wr_bresp",  64'(bresp),   64'h0);
        chk("wr_req_dn", 64'(per_req), 64'h0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("wr_b_done", 64'({bvalid, awready, wready}), 64'h3);

        // Read with three wait cycles before ack
        araddr = BASE + 32'h4; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        chk("rd_per_req",  64'({per_req, per_we}), 64'h2);
        chk("rd_per_addr", 64'(per_addr), 64'h4);
        step();
        step();
        step();
        per_ack = 1'b1; per_rdata = 32'h12345678;
        chk("rd_rdata_zero_no_valid", 64'({rvalid, rdata}), 64'h0);
        step();
        per_ack = 1'b0; per_rdata = '0;
        chk("rd_rvalid_t5", 64'(rvalid), 64'h1);
        chk("rd_rdata",     64'(rdata),  64'h12345678);
        chk("rd_rresp",     64'(rresp),  64'h0);
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("rd_after_hs", 64'({rvalid, rdata}), 64'h0);

        // Read just past the window -> DECERR, no peripheral access
        araddr = BASE + 32'h1000; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        chk("dec_no_req_t1", 64'({per_req, rvalid}), 64'h0);
        step();
        chk("dec_rvalid_t2", 64'(rvalid),  64'h1);
        chk("dec_rresp",     64'(rresp),   64'h3);
        chk("dec_rdata",     64'(rdata),   64'h0);
        chk("dec_no_req_t2", 64'(per_req), 64'h0);
        rready = 1'b1;
        step();
        rready = 1'b0;

        // Write that is never acked -> SLVERR after 15 cycles of per_req
        awaddr = BASE + 32'h8; awvalid = 1'b1;
        wdata = 32'h0000_00AA; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        cnt = 0;
        while (per_req && cnt < 40) begin
            cnt++;
            step();
        end
        chk("to_req_cycles", 64'(cnt),    64'd15);
        chk("to_bvalid",     64'(bvalid), 64'h1);
        chk("to_bresp",      64'(bresp),  64'h2);
        bready = 1'b1;
        step();
        bready = 1'b0;

        // First contest: read wins, then the held write
        awaddr = BASE + 32'h20; awvalid = 1'b1;
        wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
        araddr = BASE + 32'h30; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step();
        chk("arb1_first_read", 64'({per_req, per_we, per_addr}), 64'h2_0000_0030);
        per_ack = 1'b1; per_rdata = 32'h0000_A5A5;
        step();
        per_ack = 1'b0; per_rdata = '0;
        chk("arb1_rdata", 64'({rvalid, rdata}), 64'h1_0000_A5A5);
        rready = 1'b1;
        step();
        rready = 1'b0;
        step();
        chk("arb1_then_write", 64'({per_req, per_we, per_addr}), 64'h3_0000_0020);
        per_ack = 1'b1;
        step();
        per_ack = 1'b0;
        chk("arb1_bvalid", 64'({bvalid, bresp}), 64'h4);
        bready = 1'b1;
        step();
        bready = 1'b0;

        // Second contest: write wins; B is back-pressured for 10 cycles
        awaddr = BASE + 32'h40; awvalid = 1'b1;
        wdata = 32'h3333_4444; wstrb = 4'b1100; wvalid = 1'b1;
        araddr = BASE + 32'h50; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step();
        chk("arb2_first_write", 64'({per_req, per_we, per_addr}), 64'h3_0000_0040);
        chk("arb2_be", 64'(per_be), 64'hC);
        per_ack = 1'b1;
        step();
        per_ack = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bvalid && !awready) cnt++;
            step();
        end
        chk("bp_bvalid_held", 64'(cnt), 64'd10);
        chk("bp_ready_low", 64'({bvalid, awready, wready, arready}), 64'h8);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bp_released", 64'(bvalid), 64'h0);
        step();
        chk("arb2_then_read", 64'({per_req, per_we, per_addr}), 64'h2_0000_0050);
        per_ack = 1'b1; per_rdata = 32'hCAFE_F00D;
        step();
        per_ack = 1'b0; per_rdata = '0;
        chk("arb2_rdata", 64'({rvalid, rresp, rdata}), 64'h4_CAFE_F00D);
        rready = 1'b1;
        step();
        rready = 1'b0;

        // Reset in the middle of an access, then a clean write
        awaddr = BASE + 32'h60; awvalid = 1'b1;
        wdata = 32'h5555_6666; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        chk("mid_req_before_rst", 64'(per_req), 64'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req_dropped", 64'({per_req, awready, bvalid}), 64'h0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_ready", 64'({awready, wready, arready}), 64'h7);
        awaddr = BASE + 32'h8; awvalid = 1'b1;
        wdata = 32'h7777_8888; wstrb = 4'b0101; wvalid = 1'b1;
        per_ack = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        chk("post_rst_req", 64'({per_req, per_we, per_addr}), 64'h3_0000_0008);
        step();
        per_ack = 1'b0;
        chk("post_rst_okay", 64'({bvalid, bresp}), 64'h4);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("post_rst_done", 64'({bvalid, awready}), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_bridge.md
AXI4_LITE_SLAVE_BRIDGE -- requirements
Module: axi4_lite_slave_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI and peripheral address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values are 32 and 64; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first byte address decoded by this slave.
REQ-004 SHALL have parameter SIZE_BYTES, default 4096, decoded window size in bytes; must be a power of two.
REQ-005 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles to wait for per_ack; range 1..255.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL provide the AXI4-Lite slave ports S_AXI_AW{ADDR,VALID,READY}, S_AXI_W{DATA,STRB[STRB_WIDTH],VALID,READY}, S_AXI_B{RESP[2],VALID,READY}, S_AXI_AR{ADDR,VALID,READY} and S_AXI_R{DATA,RESP[2],VALID,READY}, with standard directions.
REQ-009 SHALL provide per_req, output, 1 bit: a peripheral access is in progress.
REQ-010 SHALL provide per_we, output, 1 bit: 1 = write access, 0 = read access.
REQ-011 SHALL provide per_addr, output, ADDR_WIDTH bits: the address offset from BASE_ADDR.
REQ-012 SHALL provide per_wdata, output, DATA_WIDTH bits, and per_be, output, STRB_WIDTH bits: write data and byte enables.
REQ-013 SHALL provide per_rdata, input, DATA_WIDTH bits, and per_ack, input, 1 bit: the peripheral completes the access in any cycle in which per_req and per_ack are both 1.

Function
REQ-014 SHALL drive S_AXI_AWREADY high while no AW is held and no B is pending; AW SHALL be captured on AWVALID&&AWREADY.
REQ-015 SHALL drive S_AXI_WREADY high while no W is held and no B is pending; AW and W SHALL be accepted in either order or in the same cycle.
REQ-016 SHALL drive S_AXI_ARREADY high while no AR is held and no R is pending.
REQ-017 SHALL implement an access FSM with states IDLE, ACCESS and RESP.
REQ-018 In IDLE, the FSM SHALL see a write ready when AW and W are both held, and a read ready when AR is held.
REQ-019 When both are ready in the same cycle, the FSM SHALL grant the type not granted last; after reset, read wins.
REQ-020 On a grant with the address in [BASE_ADDR, BASE_ADDR+SIZE_BYTES), the FSM SHALL go to ACCESS and assert per_req in the next cycle, with per_addr = addr - BASE_ADDR.
REQ-021 In ACCESS, per_we, per_addr, per_wdata and per_be SHALL be driven from registers and held stable until completion.
REQ-022 A grant with an out-of-range address SHALL NOT assert per_req; the FSM SHALL go directly to RESP with DECERR (2'b11).
REQ-023 In ACCESS, per_ack=1 SHALL end the access: read data SHALL be registered from per_rdata, and RESP SHALL be OKAY (2'b00).
REQ-024 A wait counter SHALL increment each ACCESS cycle without per_ack; reaching TIMEOUT SHALL drop per_req and give SLVERR (2'b10), with RDATA = 0.
REQ-025 On entering RESP, BVALID or RVALID SHALL be set the next cycle and held until BREADY or RREADY, respectively.
REQ-026 On the B or R handshake, the FSM SHALL clear the held channel(s) and return to IDLE.
REQ-027 The minimum latency SHALL be: AW/W accepted at T, per_req at T+1, per_ack at T+1, BVALID at T+2; reads SHALL have the same timing.
REQ-028 DECERR latency SHALL be: accepted at T, BVALID or RVALID at T+2.
REQ-029 Only one peripheral access SHALL be outstanding; a read SHALL be capturable while a write is in ACCESS and vice versa.
REQ-030 S_AXI_RDATA SHALL be 0 whenever RVALID=0.

Reset
REQ-031 While rst=0, AWREADY, WREADY, ARREADY, BVALID, RVALID and per_req SHALL be 0.
REQ-032 While rst=0, BRESP, RRESP, RDATA, per_addr, per_wdata, per_be and per_we SHALL be 0, and the FSM SHALL be in IDLE.
REQ-033 Reset asserted mid-transaction SHALL discard all held channels and the access in flight, with no per_ack requirement.
REQ-034 The first READY SHALL rise in the first clk edge after rst deasserts.

Verification
REQ-035 Write AW=BASE_ADDR+0x10 at T, then W=0xDEADBEEF with STRB=4'b0011 at T+3, ack at once -> per_addr=0x10, per_be=0011, BRESP=00.
REQ-036 Read at BASE_ADDR+0x4 with per_ack after 3 wait cycles and per_rdata=0x12345678 -> RDATA=0x12345678, RRESP=00, RVALID 5 cycles after AR.
REQ-037 Read at BASE_ADDR+SIZE_BYTES -> no per_req, RRESP=11, RDATA=0.
REQ-038 Write with per_ack tied 0, TIMEOUT=15 -> per_req high 15 cycles, then BRESP=10.
REQ-039 AW+W and AR in the same cycle, twice -> first order read then write, second order write then read; BREADY held low for 10 cycles -> BVALID held and AWREADY=0.
REQ-040 rst pulsed low during ACCESS -> per_req=0 immediately, then a clean write completes with OKAY.
